mem_arbiter: RTL and testbench

- Shares the single-port system `memory` (`clk`, `wr_en`, `addr`, `wr_data`, `rd_data`, combinational read) between two requesters.
- Port 0 is the `cpu` data port. Port 1 is the secondary master (debug loader / DMA).
- Fixed priority to port 0, with a starvation guard for port 1 and bounded lock (burst) ownership.
- Sits between `cpu` and `memory` in the top level. The `cpu` stalls while `gnt0` is low.

---
 rtl/project_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_arb_sel.sv | 42 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/project_pkg.sv
// Shared types for the memory arbiter: data word, lock FSM states and the
// owner debug encodings.
package project_pkg;

    typedef logic [7:0] word;

    typedef logic [3:0] cnt_t;
    localparam cnt_t CNT_SAT = 4'hF;

    typedef enum logic [1:0] {ARB_UNLOCKED, ARB_LOCK0, ARB_LOCK1} e_arb_state;

    typedef enum logic [1:0] {
        ARB_NONE = 2'b00,
        ARB_P0   = 2'b01,
        ARB_P1   = 2'b10
    } e_arb_owner;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory side signals of the two-port memory arbiter.
// The arbiter takes the slave view; the CPU/DMA/memory environment takes the master view.
interface mem_arbiter_if;
    import project_pkg::*;

    logic       req0, we0, lock0;
    word        addr0, wdata0;
    logic       gnt0, rvalid0;
    word        rdata0;

    logic       req1, we1, lock1;
    word        addr1, wdata1;
    logic       gnt1, rvalid1;
    word        rdata1;

    logic       ram_wr_en;
    word        ram_addr, ram_wr_data, ram_rd_data;
    logic [1:0] owner;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  ram_rd_data,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output ram_wr_en, ram_addr, ram_wr_data, owner
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output ram_rd_data,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  ram_wr_en, ram_addr, ram_wr_data, owner
    );

endinterface

// File: rtl/mem_arbiter_arb_sel.sv
// Purely combinational grant selection: lock owner, then starvation guard,
// then fixed priority to port 0.
module arb_sel
    import project_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  e_arb_state state_i,
    input  cnt_t       wait_cnt_i,
    input  cnt_t       lock_cnt_i,
    input  logic       req0_i,
    input  logic       req1_i,
    output logic       gnt0_o,
    output logic       gnt1_o
);

    localparam cnt_t MAX_WAIT_C = 4'(MAX_WAIT);
    localparam cnt_t MAX_LOCK_C = 4'(MAX_LOCK);

    logic lock_ok;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt0_o  = 1'b0;
        gnt1_o  = 1'b0;
        lock_ok = (lock_cnt_i < MAX_LOCK_C);

        if (state_i == ARB_LOCK0 && req0_i && lock_ok) begin
            gnt0_o = 1'b1;
        end else if (state_i == ARB_LOCK1 && req1_i && lock_ok) begin
            gnt1_o = 1'b1;
        end else if (wait_cnt_i >= MAX_WAIT_C && req1_i) begin
            gnt1_o = 1'b1;
        end else if (req0_i) begin
            gnt0_o = 1'b1;
        end else if (req1_i) begin
            gnt1_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port system memory: combinational
// same-cycle grant, bounded lock bursts, starvation guard for port 1.
module mem_arbiter
    import project_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam cnt_t MAX_LOCK_C = 4'(MAX_LOCK);

    e_arb_state state_q, state_d;
    cnt_t       lock_cnt_q, lock_cnt_d;
    cnt_t       wait_cnt_q, wait_cnt_d;
    logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    word        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic       gnt0, gnt1;

    arb_sel #(
        .MAX_WAIT (MAX_WAIT),
        .MAX_LOCK (MAX_LOCK)
    ) u_arb_sel (
        .state_i    (state_q),
        .wait_cnt_i (wait_cnt_q),
        .lock_cnt_i (lock_cnt_q),
        .req0_i     (bus.req0),
        .req1_i     (bus.req1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q    <= ARB_UNLOCKED;
            lock_cnt_q <= '0;
            wait_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // A lock that reaches MAX_LOCK drops to UNLOCKED even if the same port wins again.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB_UNLOCKED: begin
                if (gnt0 && bus.lock0) begin
                    state_d    = ARB_LOCK0;
                    lock_cnt_d = 4'd1;
                end else if (gnt1 && bus.lock1) begin
                    state_d    = ARB_LOCK1;
                    lock_cnt_d = 4'd1;
                end
            end
            ARB_LOCK0: begin
                if (gnt0 && bus.lock0 && lock_cnt_q < MAX_LOCK_C) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end else begin
                    state_d    = ARB_UNLOCKED;
                    lock_cnt_d = '0;
                end
            end
            ARB_LOCK1: begin
                if (gnt1 && bus.lock1 && lock_cnt_q < MAX_LOCK_C) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end else begin
                    state_d    = ARB_UNLOCKED;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB_UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase

        wait_cnt_d = wait_cnt_q;
        if (gnt1 || !bus.req1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_SAT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rvalid0_d = gnt0 && !bus.we0;
        rvalid1_d = gnt1 && !bus.we1;
        rdata0_d  = rvalid0_d ? bus.ram_rd_data : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.ram_rd_data : rdata1_q;
    end

    // Port 0 drives the memory address/data when idle.
    always_comb begin
        bus.gnt0        = gnt0;
        bus.gnt1        = gnt1;
        bus.ram_addr    = gnt1 ? bus.addr1 : bus.addr0;
        bus.ram_wr_data = gnt1 ? bus.wdata1 : bus.wdata0;
        bus.ram_wr_en   = (gnt0 && bus.we0) || (gnt1 && bus.we1);
        if (gnt0) begin
            bus.owner = ARB_P0;
        end else if (gnt1) begin
            bus.owner = ARB_P1;
        end else begin
            bus.owner = ARB_NONE;
        end
        bus.rvalid0 = rvalid0_q;
        bus.rvalid1 = rvalid1_q;
        bus.rdata0  = rdata0_q;
        bus.rdata1  = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, shadow copy of
// expected contents and per-port read-data scoreboards.
module tb_mem_arbiter;
    import project_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .MAX_WAIT (4),
        .MAX_LOCK (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word mem [256];
    assign bus.ram_rd_data = mem[bus.ram_addr];
    always @(posedge clk) if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;

    int  total = 0;
    int  bad   = 0;
    word shadow [256];
    word q0 [$];
    word q1 [$];

    task automatic drive0(input logic r, input logic w, input logic l, input word a, input word d);
        bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l, input word a, input word d);
        bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic idle_all();
        drive0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Advance one clock; read data pushed this cycle must appear exactly one cycle later.
    task automatic step();
        word exp;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (q0.size() > 0) begin
            exp = q0.pop_front();
            if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== exp) begin
                bad++;
                $display("FAIL rd0: rvalid0=%b rdata0=%h, want rvalid0=1 rdata0=%h", bus.rvalid0, bus.rdata0, exp);
            end
        end else if (bus.rvalid0 !== 1'b0) begin
            bad++;
            $display("FAIL rvalid0_idle: rvalid0=%b, want 0", bus.rvalid0);
        end
        total++;
        if (q1.size() > 0) begin
            exp = q1.pop_front();
            if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== exp) begin
                bad++;
                $display("FAIL rd1: rvalid1=%b rdata1=%h, want rvalid1=1 rdata1=%h", bus.rvalid1, bus.rdata1, exp);
            end
        end else if (bus.rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL rvalid1_idle: rvalid1=%b, want 0", bus.rvalid1);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.owner !== 2'b00 || bus.ram_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_comb: gnt0=%b gnt1=%b owner=%b wr_en=%b, want all 0",
                     bus.gnt0, bus.gnt1, bus.owner, bus.ram_wr_en);
        end
        total++;
        if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h, want 0 0 00 00",
                     bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            idle_all();
            #1;
            total++;
            if (bus.ram_wr_en !== 1'b0 || bus.owner !== 2'b00 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
                bad++;
                $display("FAIL idle[%0d]: wr_en=%b owner=%b gnt0=%b gnt1=%b, want all 0",
                         k, bus.ram_wr_en, bus.owner, bus.gnt0, bus.gnt1);
            end
            step();
        end
        drive0(1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C);
        #1;
        total++;
        if (bus.gnt0 !== 1'b1 || bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 8'hFF ||
            bus.ram_wr_data !== 8'h3C || bus.owner !== 2'b01) begin
            bad++;
            $display("FAIL write_ff: gnt0=%b wr_en=%b addr=%h data=%h owner=%b, want 1 1 ff 3c 01",
                     bus.gnt0, bus.ram_wr_en, bus.ram_addr, bus.ram_wr_data, bus.owner);
        end
        shadow[8'hFF] = 8'h3C;
        step();
        idle_all();
        step();
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
        drive1(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        #1;
        total++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL wr_cycle0: gnt0=%b gnt1=%b, want 1 0", bus.gnt0, bus.gnt1);
        end
        shadow[8'h10] = 8'hA5;
        step();
        drive0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        total++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.ram_addr !== 8'h10 || bus.ram_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rd_cycle1: gnt1=%b gnt0=%b addr=%h wr_en=%b, want 1 0 10 0",
                     bus.gnt1, bus.gnt0, bus.ram_addr, bus.ram_wr_en);
        end
        q1.push_back(shadow[8'h10]);
        step();
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive0(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
        #1;
        q0.push_back(shadow[8'hFF]);
        step();
        idle_all();
        total++;
        if (bus.rdata1 !== 8'hA5) begin
            bad++;
            $display("FAIL rdata1_hold: rdata1=%h, want a5", bus.rdata1);
        end
        step();
    endtask

    task automatic test_starvation();
        logic e1;
        for (int k = 0; k < 15; k++) begin
            drive0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
            drive1(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
            #1;
            e1 = (k % 5 == 4);
            total++;
            if (bus.gnt0 !== !e1 || bus.gnt1 !== e1) begin
                bad++;
                $display("FAIL starve[%0d]: gnt0=%b gnt1=%b, want %b %b", k, bus.gnt0, bus.gnt1, !e1, e1);
            end
            if (e1) q1.push_back(shadow[8'hFF]);
            else    q0.push_back(shadow[8'h10]);
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_burst();
        logic [7:0] pat = 8'b0111_0000;
        int w = 0;
        for (int k = 0; k < 8; k++) begin
            drive0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
            if (w < 3) drive1(1'b1, 1'b1, (w < 2), word'(8'h20 + w), word'(8'h51 + w));
            else       drive1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            #1;
            total++;
            if (bus.gnt1 !== pat[k] || bus.gnt0 !== !pat[k]) begin
                bad++;
                $display("FAIL burst[%0d]: gnt0=%b gnt1=%b, want %b %b", k, bus.gnt0, bus.gnt1, !pat[k], pat[k]);
            end
            if (pat[k]) begin
                shadow[8'h20 + w] = word'(8'h51 + w);
                w++;
            end else begin
                q0.push_back(shadow[8'h10]);
            end
            step();
        end
        idle_all();
        for (int a = 8'h20; a <= 8'h22; a++) begin
            drive0(1'b1, 1'b0, 1'b0, word'(a), 8'h00);
            #1;
            q0.push_back(shadow[a]);
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_lock_max();
        logic e1;
        for (int k = 0; k < 10; k++) begin
            drive0(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
            drive1(1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
            #1;
            e1 = (k == 8);
            total++;
            if (bus.gnt0 !== !e1 || bus.gnt1 !== e1) begin
                bad++;
                $display("FAIL lockmax[%0d]: gnt0=%b gnt1=%b, want %b %b", k, bus.gnt0, bus.gnt1, !e1, e1);
            end
            total++;
            if (bus.owner !== (e1 ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL lockmax_owner[%0d]: owner=%b, want %b", k, bus.owner, (e1 ? 2'b10 : 2'b01));
            end
            if (e1) q1.push_back(shadow[8'h21]);
            else    q0.push_back(shadow[8'h20]);
            step();
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_reset_mid_lock();
        drive1(1'b1, 1'b0, 1'b1, 8'h22, 8'h00);
        #1;
        total++;
        if (bus.gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL lock1_enter: gnt1=%b, want 1", bus.gnt1);
        end
        q1.push_back(shadow[8'h22]);
        step();
        drive0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        drive1(1'b1, 1'b0, 1'b1, 8'h21, 8'h00);
        rst = 1'b0;
        #1;
        total++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL lock1_hold_in_reset: gnt0=%b gnt1=%b, want 0 1", bus.gnt0, bus.gnt1);
        end
        step();
        total++;
        if (bus.rdata1 !== 8'h00 || dut.state_q !== ARB_UNLOCKED || dut.wait_cnt_q !== 4'd0 ||
            dut.lock_cnt_q !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: rdata1=%h state=%0d wait=%0d lock=%0d, want 00 0 0 0",
                     bus.rdata1, dut.state_q, dut.wait_cnt_q, dut.lock_cnt_q);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: gnt0=%b gnt1=%b, want 1 0", bus.gnt0, bus.gnt1);
        end
        q0.push_back(shadow[8'h10]);
        step();
        idle_all();
        step();
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: q0=%0d q1=%0d, want 0 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_idle();
        test_write_read();
        test_starvation();
        test_burst();
        test_lock_max();
        test_reset_mid_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
